// File: rtl/addr_sequencer.sv
// addr_sequencer
//   Windowed address generator for the TX/RX buffer datapath. It sweeps
//   [base..limit] of an AW-bit address space. The sweep can count up or
//   down. In wrap mode it runs as a continuous ring; in stop mode it makes a
//   single pass and then returns to idle. A controller launches a burst with
//   start, watches busy, and sees done when the burst ends.
//
// Ports
//   clk    in   clock, rising edge
//   clr    in   asynchronous active-low reset
//   start  in   launch request (IDLE only)
//   base   in   [AW] lower window bound, sampled on accepted start
//   limit  in   [AW] upper window bound, sampled on accepted start
//   mode   in   [2]  bit0: 0=wrap 1=stop, bit1: 0=up 1=down
//   inc    in   advance request (RUN only)
//   abort  in   cancel burst (RUN only), wins over inc
//   adrs   out  [AW] current address, registered
//   busy   out  high while in RUN
//   done   out  1-cycle pulse, stop-mode burst complete
//   wrap   out  1-cycle pulse, wrap-mode address wrapped
//   err    out  1-cycle pulse, start rejected because base > limit
module addr_sequencer #(
  parameter int unsigned          AW         = 4,
  parameter logic [AW-1:0]        RESET_ADRS = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] limit,
  input  logic [1:0]    mode,
  input  logic          inc,
  input  logic          abort,
  output logic [AW-1:0] adrs,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic          err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state, state_nx;
  logic [AW-1:0] base_q, limit_q, base_nx, limit_nx;
  logic [1:0]    mode_q, mode_nx;
  logic [AW-1:0] adrs_nx;
  logic          done_nx, wrap_nx, err_nx;

  // Window endpoints. The latched copies are used while running. The live
  // inputs give the first address on an accepted start.
  logic          down_q, stop_q;
  logic [AW-1:0] sv_q, ev_q, sv_in;
  logic          start_ok;

  assign down_q   = mode_q[1];
  assign stop_q   = mode_q[0];
  assign sv_q     = down_q  ? limit_q : base_q;
  assign ev_q     = down_q  ? base_q  : limit_q;
  assign sv_in    = mode[1] ? limit   : base;
  assign start_ok = (base <= limit);

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      adrs    <= RESET_ADRS;
      base_q  <= '0;
      limit_q <= '0;
      mode_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      adrs    <= adrs_nx;
      base_q  <= base_nx;
      limit_q <= limit_nx;
      mode_q  <= mode_nx;
      // busy is driven from the next state. It therefore rises on the edge
      // that accepts start and falls on the edge that ends the burst.
      busy    <= (state_nx == RUN);
      done    <= done_nx;
      wrap    <= wrap_nx;
      err     <= err_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && start_ok) state_nx = RUN;
      RUN: begin
        if (abort)                                state_nx = IDLE;
        else if (inc && (adrs == ev_q) && stop_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and latches
  always_comb begin
    adrs_nx  = adrs;
    base_nx  = base_q;
    limit_nx = limit_q;
    mode_nx  = mode_q;
    done_nx  = 1'b0;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            base_nx  = base;
            limit_nx = limit;
            mode_nx  = mode;
            adrs_nx  = sv_in;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (!abort && inc) begin
          if (adrs != ev_q) begin
            // The end value is never crossed, so +/-1 cannot leave the
            // window or wrap past 0 / 2^AW-1.
            adrs_nx = down_q ? (adrs - ONE) : (adrs + ONE);
          end else if (!stop_q) begin
            adrs_nx = sv_q;
            wrap_nx = 1'b1;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Parametrised address generator for the TX/RX buffer datapath; successor to the fixed 2-bit address counter.
- Sweeps a programmable window [base..limit] of an AW-bit address space, counting up or down, in wrap (continuous ring) or stop (one-shot burst) mode.
- Uses a start/busy/done handshake so the TX/RX controllers can launch bursts and detect completion without tracking the count themselves.

Parameters:
AW, 4, address width in bits (≥1); address space 0..2^AW-1.
RESET_ADRS, 0, value loaded into adrs on clr (AW bits).

Ports:
clk  input  1  clock, rising edge.
clr  input  1  reset, asynchronous, active-low.
start  input  1  launch request; honoured only in IDLE.
base  input  AW  lower window bound; sampled on accepted start.
limit  input  AW  upper window bound; sampled on accepted start.
mode  input  2  bit0: 0=wrap, 1=stop; bit1: 0=up, 1=down; sampled on accepted start.
inc  input  1  advance request; honoured only in RUN.
abort  input  1  cancel the burst; honoured only in RUN.
adrs  output  AW  current address (registered).
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when a stop-mode burst completes.
wrap  output  1  one-cycle pulse when the address wraps in wrap mode.
err  output  1  one-cycle pulse when start is rejected (base > limit).

Behaviour:
- Reset (clr low, asynchronous, any state):
  - State goes to IDLE; adrs=RESET_ADRS; busy=0, done=0, wrap=0, err=0; latched base, limit and mode are cleared to 0.
  - A reset in the middle of a burst abandons it immediately with no done pulse.
- All outputs are registered; done, wrap and err default to 0 on every edge unless set as described below.
- Start value: base for up modes, limit for down modes. End value: limit for up modes, base for down modes.
- IDLE state:
  - start=1 and base ≤ limit (unsigned): latch base, limit and mode; adrs←start value; go to RUN. busy is 1 after that same edge (zero-cycle latency).
  - start=1 and base > limit: err=1 for one cycle; stay in IDLE; adrs and latches unchanged.
  - inc and abort are ignored.
- RUN state:
  - Priority is abort > inc.
  - abort=1: go to IDLE; adrs holds its current value; no done pulse.
  - inc=1 and adrs ≠ end value: adrs±1 (+1 for up, −1 for down). Arithmetic is modulo 2^AW but never leaves the window.
  - inc=1 and adrs = end value, wrap mode: adrs←start value; wrap=1 for one cycle; stay in RUN.
  - inc=1 and adrs = end value, stop mode: adrs holds the end value; done=1 for one cycle; go to IDLE (busy=0 after the same edge).
  - inc=0: hold.
  - start is ignored; base, limit and mode changes have no effect until the next accepted start.
- Single-entry window (base=limit):
  - Wrap mode: every inc pulses wrap and adrs stays constant.
  - Stop mode: the first inc completes the burst.
- Full-range window (base=0, limit=2^AW−1) behaves as a plain modulo counter. The boundaries 0 and 2^AW−1 must not cause overflow artefacts.
- start asserted on the same edge that produces done is ignored, because the state is still RUN on that edge. The controller must re-assert start one cycle later.
- adrs is not forced back to RESET_ADRS on returning to IDLE; it holds the last address.

Test Plan:
- Reset: clr low while in RUN with adrs=5 → adrs=RESET_ADRS=0 and busy=0 immediately, before any clock edge; no done pulse.
- Up/stop: AW=4, base=3, limit=6, mode=2'b01, start, then inc held high → adrs 3,4,5,6; done pulses for 1 cycle on the 4th inc; busy falls on the same edge; adrs holds 6.
- Down/wrap: base=2, limit=4, mode=2'b10, inc continuous → adrs 4,3,2,4,3,…; wrap pulses on each 2→4 transition; busy stays 1.
- Full range up/wrap: base=0, limit=15, mode=2'b00 → adrs 0..15 then 0, with a wrap pulse at the 15→0 step; no glitch at the MSB.
- Error and abort:
  - start with base=9, limit=4 → err pulses 1 cycle; busy stays 0; adrs unchanged.
  - In RUN at adrs=7, assert abort and inc together → IDLE, adrs=7, no done.
- Ignored inputs: start and new base/limit during RUN → no effect on the sequence; inc while IDLE → adrs unchanged; base=limit=9 in stop mode → done on the first inc.
